// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: load-use, branch-flush, stall and mul/div scoreboard hazard control.
// Ports: ID/EX hazard inputs, mul/div issue/done, redirect, stall -> pipe enables/flushes, pc_en,
// status (load_stall, md_stall, sb_busy, stall_timeout). Optional: HAZARD_WATCHDOG_EN.
module hazard_ctrl_sb #(
  parameter int NREGS     = 32,
  parameter int RA_W      = 5,
  parameter int LU_CYCLES = 1,
  parameter int FLUSH_CYC = 1,
  parameter int WD_MAX    = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_rd_wr,
  input  logic [RA_W-1:0]  ex_rd,
  input  logic             ex_load_inst,
  input  logic             md_issue,
  input  logic [RA_W-1:0]  md_issue_rd,
  input  logic             md_done,
  input  logic [RA_W-1:0]  md_done_rd,
  input  logic             jump_branch_taken,
  input  logic             invalid_inst,
  input  logic             stall,
  output logic             if_id_pipeline_flush,
  output logic             if_id_pipeline_en,
  output logic             id_ex_pipeline_flush,
  output logic             id_ex_pipeline_en,
  output logic             pc_en,
  output logic             load_stall,
  output logic             md_stall,
  output logic [NREGS-1:0] sb_busy,
  output logic             stall_timeout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LU    = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam int CNT_W = 8;

  logic [1:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [NREGS-1:0] busy_q, busy_n, busy_eff;
  logic [NREGS-1:0] done_mask, issue_mask;
  logic             lu_hit, sb_hit;

  always_comb begin
    done_mask  = '0;
    issue_mask = '0;
    if (md_done)
      done_mask[md_done_rd] = 1'b1;
    if (md_issue && md_issue_rd != '0)
      issue_mask[md_issue_rd] = 1'b1;
  end

  // A register completing this cycle is forwarded from WB, so it no
  // longer blocks ID. Issue is applied after clear so a same-cycle
  // set/clear of one register leaves it busy.
  always_comb begin
    busy_eff  = busy_q & ~done_mask;
    busy_n    = busy_eff | issue_mask;
    busy_n[0] = 1'b0;
  end

  always_comb begin
    lu_hit = ex_load_inst && (ex_rd != '0) &&
             ((id_rs1_used && id_rs1 == ex_rd) ||
              (id_rs2_used && id_rs2 == ex_rd));
    sb_hit = id_valid &&
             ((id_rs1_used && busy_eff[id_rs1]) ||
              (id_rs2_used && busy_eff[id_rs2]) ||
              (id_rd_wr && busy_eff[id_rd]));
  end

  always_comb begin
    if_id_pipeline_flush = 1'b0;
    if_id_pipeline_en    = 1'b1;
    id_ex_pipeline_flush = 1'b0;
    id_ex_pipeline_en    = 1'b1;
    pc_en                = 1'b1;
    load_stall           = 1'b0;
    md_stall             = 1'b0;
    state_n              = state;
    cnt_n                = cnt;
    if (rst) begin
      if_id_pipeline_flush = 1'b1;
      id_ex_pipeline_flush = 1'b1;
      pc_en                = 1'b0;
      state_n              = S_IDLE;
      cnt_n                = '0;
    end else if (jump_branch_taken) begin
      if_id_pipeline_flush = 1'b1;
      if_id_pipeline_en    = 1'b0;
      id_ex_pipeline_flush = 1'b1;
      if (FLUSH_CYC > 1) begin
        state_n = S_FLUSH;
        cnt_n   = CNT_W'(FLUSH_CYC - 1);
      end else begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    end else if (state == S_LU) begin
      // The load has already left EX; just finish the bubble train.
      pc_en                = 1'b0;
      if_id_pipeline_en    = 1'b0;
      id_ex_pipeline_flush = 1'b1;
      load_stall           = 1'b1;
      cnt_n                = cnt - 1'b1;
      if (cnt <= 1) begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    end else begin
      if (state == S_FLUSH) begin
        if_id_pipeline_flush = 1'b1;
        cnt_n                = cnt - 1'b1;
        if (cnt <= 1) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      end
      if (lu_hit) begin
        pc_en                = 1'b0;
        if_id_pipeline_en    = 1'b0;
        id_ex_pipeline_flush = 1'b1;
        load_stall           = 1'b1;
        if (LU_CYCLES > 1) begin
          state_n = S_LU;
          cnt_n   = CNT_W'(LU_CYCLES - 1);
        end
      end else if (sb_hit) begin
        pc_en                = 1'b0;
        if_id_pipeline_en    = 1'b0;
        id_ex_pipeline_flush = 1'b1;
        md_stall             = 1'b1;
      end else if (stall) begin
        pc_en             = 1'b0;
        if_id_pipeline_en = 1'b0;
        id_ex_pipeline_en = 1'b0;
      end else if (invalid_inst) begin
        id_ex_pipeline_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      busy_q <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      busy_q <= busy_n;
    end
  end

  assign sb_busy = busy_q;

`ifdef HAZARD_WATCHDOG_EN
  localparam int WD_W = $clog2(WD_MAX + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      wd_flag <= 1'b0;
    end else if (pc_en) begin
      wd_cnt <= '0;
    end else begin
      if (wd_cnt != WD_W'(WD_MAX))
        wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_W'(WD_MAX - 1))
        wd_flag <= 1'b1;
    end
  end

  assign stall_timeout = wd_flag;
`else
  assign stall_timeout = 1'b0;
`endif

endmodule
